// File: rtl/csr_arbiter_if.sv
// Signal bundle shared by the two CSR masters, the arbiter and the OR-reduced CSR slave bus.
interface csr_arbiter_if;
    logic       m0_req;
    logic [4:0] m0_a;
    logic       m0_we;
    logic [7:0] m0_wdata;
    logic       m0_lock;
    logic       m0_ack;
    logic [7:0] m0_rdata;

    logic       m1_req;
    logic [4:0] m1_a;
    logic       m1_we;
    logic [7:0] m1_wdata;
    logic       m1_lock;
    logic       m1_ack;
    logic [7:0] m1_rdata;

    logic [4:0] csr_a;
    logic [7:0] csr_do;
    logic       csr_we;
    logic [7:0] csr_di;

    logic       busy;
    logic       owner;
    logic       lock_timeout;

    modport slave (
        input  m0_req, m0_a, m0_we, m0_wdata, m0_lock,
        output m0_ack, m0_rdata,
        input  m1_req, m1_a, m1_we, m1_wdata, m1_lock,
        output m1_ack, m1_rdata,
        output csr_a, csr_do, csr_we,
        input  csr_di,
        output busy, owner, lock_timeout
    );

    modport master (
        output m0_req, m0_a, m0_we, m0_wdata, m0_lock,
        input  m0_ack, m0_rdata,
        output m1_req, m1_a, m1_we, m1_wdata, m1_lock,
        input  m1_ack, m1_rdata,
        input  csr_a, csr_do, csr_we,
        output csr_di,
        input  busy, owner, lock_timeout
    );
endinterface

// File: rtl/csr_arbiter.sv
// Round-robin arbiter sharing the 5-bit address / 8-bit data CSR bus between two masters,
// with an ownership lock for atomic read-modify-write and an idle-lock timeout.
module csr_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [4:0]  IDLE_ADDR    = 5'h1f,
    parameter logic [7:0]  LOCK_TIMEOUT = 8'd255
) (
    input  logic         clk,
    input  logic         rst,
    csr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t     r_state,        w_state_nxt;
    logic [1:0] r_wait_cnt,     w_wait_cnt_nxt;
    logic       r_ptr,          w_ptr_nxt;
    logic       r_locked,       w_locked_nxt;
    logic [7:0] r_lock_cnt,     w_lock_cnt_nxt;
    logic       r_owner,        w_owner_nxt;
    logic [4:0] r_csr_a,        w_csr_a_nxt;
    logic [7:0] r_csr_do,       w_csr_do_nxt;
    logic       r_csr_we,       w_csr_we_nxt;
    logic       r_m0_ack,       w_m0_ack_nxt;
    logic       r_m1_ack,       w_m1_ack_nxt;
    logic [7:0] r_m0_rdata,     w_m0_rdata_nxt;
    logic [7:0] r_m1_rdata,     w_m1_rdata_nxt;
    logic       r_busy,         w_busy_nxt;
    logic       r_lock_timeout, w_lock_timeout_nxt;

    logic       w_own_req;
    logic       w_own_lock;
    logic       w_grant;
    logic       w_winner;
    logic       w_wait_last;
    logic       w_expire;
    logic [8:0] w_cnt_inc;

    assign w_own_req   = r_owner ? bus.m1_req  : bus.m0_req;
    assign w_own_lock  = r_owner ? bus.m1_lock : bus.m0_lock;
    assign w_wait_last = (r_wait_cnt == WAIT_LAST);
    assign w_cnt_inc   = {1'b0, r_lock_cnt} + 9'd1;
    assign w_expire    = (r_state == S_IDLE) && r_locked && w_own_lock && !w_own_req &&
                         (w_cnt_inc >= {1'b0, LOCK_TIMEOUT});

    // While locked only the lock owner can win; otherwise the pointer breaks ties.
    always_comb begin
        w_grant  = 1'b0;
        w_winner = r_ptr;
        if (r_locked) begin
            w_grant  = w_own_req;
            w_winner = r_owner;
        end else if (bus.m0_req && bus.m1_req) begin
            w_grant  = 1'b1;
            w_winner = r_ptr;
        end else if (bus.m0_req || bus.m1_req) begin
            w_grant  = 1'b1;
            w_winner = bus.m1_req;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_ADDR;
            S_ADDR:  w_state_nxt = S_WAIT;
            S_WAIT:  if (w_wait_last) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default before the case so no path can infer a latch.
        w_wait_cnt_nxt     = r_wait_cnt;
        w_ptr_nxt          = r_ptr;
        w_locked_nxt       = r_locked;
        w_lock_cnt_nxt     = r_lock_cnt;
        w_owner_nxt        = r_owner;
        w_csr_a_nxt        = r_csr_a;
        w_csr_do_nxt       = r_csr_do;
        w_csr_we_nxt       = 1'b0;
        w_m0_ack_nxt       = 1'b0;
        w_m1_ack_nxt       = 1'b0;
        w_m0_rdata_nxt     = r_m0_rdata;
        w_m1_rdata_nxt     = r_m1_rdata;
        w_busy_nxt         = (w_state_nxt != S_IDLE);
        w_lock_timeout_nxt = w_expire;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_owner_nxt    = w_winner;
                    w_csr_a_nxt    = w_winner ? bus.m1_a     : bus.m0_a;
                    w_csr_do_nxt   = w_winner ? bus.m1_wdata : bus.m0_wdata;
                    w_csr_we_nxt   = w_winner ? bus.m1_we    : bus.m0_we;
                    w_lock_cnt_nxt = '0;
                end
                if (r_locked && !w_own_lock) begin
                    w_locked_nxt   = 1'b0;
                    w_lock_cnt_nxt = '0;
                end else if (w_expire) begin
                    w_locked_nxt   = 1'b0;
                    w_lock_cnt_nxt = '0;
                end else if (r_locked && !w_own_req) begin
                    w_lock_cnt_nxt = (r_lock_cnt == 8'hff) ? 8'hff : w_cnt_inc[7:0];
                end
            end
            S_ADDR: begin
                w_wait_cnt_nxt = '0;
            end
            S_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                // csr_di is captured for writes as well; the master simply ignores it.
                if (w_wait_last) begin
                    if (r_owner) begin
                        w_m1_rdata_nxt = bus.csr_di;
                        w_m1_ack_nxt   = 1'b1;
                    end else begin
                        w_m0_rdata_nxt = bus.csr_di;
                        w_m0_ack_nxt   = 1'b1;
                    end
                end
            end
            S_ACK: begin
                w_ptr_nxt    = ~r_owner;
                w_locked_nxt = w_own_lock;
                w_csr_a_nxt  = IDLE_ADDR;
            end
            default: begin
                w_csr_a_nxt = IDLE_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: a mid-transfer reset must drop the strobe and suppress the ack, so every register is reset.
        if (rst) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_ptr          <= 1'b0;
            r_locked       <= 1'b0;
            r_lock_cnt     <= '0;
            r_owner        <= 1'b0;
            r_csr_a        <= IDLE_ADDR;
            r_csr_do       <= '0;
            r_csr_we       <= 1'b0;
            r_m0_ack       <= 1'b0;
            r_m1_ack       <= 1'b0;
            r_m0_rdata     <= '0;
            r_m1_rdata     <= '0;
            r_busy         <= 1'b0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_ptr          <= w_ptr_nxt;
            r_locked       <= w_locked_nxt;
            r_lock_cnt     <= w_lock_cnt_nxt;
            r_owner        <= w_owner_nxt;
            r_csr_a        <= w_csr_a_nxt;
            r_csr_do       <= w_csr_do_nxt;
            r_csr_we       <= w_csr_we_nxt;
            r_m0_ack       <= w_m0_ack_nxt;
            r_m1_ack       <= w_m1_ack_nxt;
            r_m0_rdata     <= w_m0_rdata_nxt;
            r_m1_rdata     <= w_m1_rdata_nxt;
            r_busy         <= w_busy_nxt;
            r_lock_timeout <= w_lock_timeout_nxt;
        end
    end

    assign bus.csr_a        = r_csr_a;
    assign bus.csr_do       = r_csr_do;
    assign bus.csr_we       = r_csr_we;
    assign bus.m0_ack       = r_m0_ack;
    assign bus.m1_ack       = r_m1_ack;
    assign bus.m0_rdata     = r_m0_rdata;
    assign bus.m1_rdata     = r_m1_rdata;
    assign bus.busy         = r_busy;
    assign bus.owner        = r_owner;
    assign bus.lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_csr_arbiter.sv
// Bench for csr_arbiter: directed scenarios followed by random traffic against a
// transaction-level scoreboard (expected register contents, grant order, latency).
module tb_csr_arbiter;
    localparam int         RL     = 1;
    localparam logic [4:0] IDLE_A = 5'h1f;
    localparam logic [7:0] TMO    = 8'd4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_arbiter_if bus ();

    csr_arbiter #(
        .READ_LATENCY(RL),
        .IDLE_ADDR   (IDLE_A),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] slave_mem [32];
    logic [7:0] exp_mem   [32];

    function automatic logic [7:0] init_val(input int a);
        return (a == 3) ? 8'h20 : 8'(a * 13 + 7);
    endfunction

    // Single CSR slave behind the OR-reduced bus; it drives zero for the idle address.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) slave_mem[i] <= init_val(i);
        end else if (bus.csr_we) begin
            slave_mem[bus.csr_a] <= bus.csr_do;
        end
    end
    always_comb bus.csr_di = (bus.csr_a == IDLE_A) ? 8'h00 : slave_mem[bus.csr_a];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int m, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (m == 0) ? bus.m0_ack : bus.m1_ack;
        end
        check({tag, "_ack_seen"}, seen, 1);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);
    endtask

    // Random-phase scoreboard state
    logic [4:0] ra  [2];
    logic       rwe [2];
    logic [7:0] rwd [2];
    bit         pend[2];
    bit         prev_req[2];
    bit         ack_v[2];
    logic [7:0] rd_v[2];
    int         age [2];
    int         gcyc;
    int         g_owner;
    int         pref;
    int         idx;
    bit         prev_busy;
    bit         rose;
    bit         e0, e1;

    initial begin
        rst = 1'b1;
        bus.m0_req = 0; bus.m0_a = '0; bus.m0_we = 0; bus.m0_wdata = '0; bus.m0_lock = 0;
        bus.m1_req = 0; bus.m1_a = '0; bus.m1_we = 0; bus.m1_wdata = '0; bus.m1_lock = 0;
        reset_model();
        repeat (3) @(negedge clk);

        check("rst_csr_a", bus.csr_a, IDLE_A);
        check("rst_csr_do", bus.csr_do, 0);
        check("rst_csr_we", bus.csr_we, 0);
        check("rst_m0_ack", bus.m0_ack, 0);
        check("rst_m1_ack", bus.m1_ack, 0);
        check("rst_m0_rdata", bus.m0_rdata, 0);
        check("rst_m1_rdata", bus.m1_rdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_lock_timeout", bus.lock_timeout, 0);
        rst = 1'b0;

        // m0 read of 0x03: address at T+1, ack with data at T+3, idle address at T+4
        @(negedge clk);
        bus.m0_req = 1; bus.m0_a = 5'h03; bus.m0_we = 0;
        @(negedge clk);
        check("rd_addr_csr_a", bus.csr_a, 5'h03);
        check("rd_addr_csr_we", bus.csr_we, 0);
        check("rd_addr_busy", bus.busy, 1);
        @(negedge clk);
        check("rd_wait_csr_we", bus.csr_we, 0);
        check("rd_wait_ack", bus.m0_ack, 0);
        @(negedge clk);
        check("rd_ack", bus.m0_ack, 1);
        check("rd_rdata", bus.m0_rdata, 8'h20);
        check("rd_ack_csr_we", bus.csr_we, 0);
        bus.m0_req = 0;
        @(negedge clk);
        check("rd_idle_csr_a", bus.csr_a, IDLE_A);
        check("rd_idle_busy", bus.busy, 0);
        check("rd_idle_ack", bus.m0_ack, 0);

        // m1 write 0x31 to 0x1a: one-cycle strobe at T+1, ack at T+3
        bus.m1_req = 1; bus.m1_a = 5'h1a; bus.m1_we = 1; bus.m1_wdata = 8'h31;
        @(negedge clk);
        check("wr_addr_csr_we", bus.csr_we, 1);
        check("wr_addr_csr_a", bus.csr_a, 5'h1a);
        check("wr_addr_csr_do", bus.csr_do, 8'h31);
        check("wr_addr_owner", bus.owner, 1);
        @(negedge clk);
        check("wr_wait_csr_we", bus.csr_we, 0);
        check("wr_wait_csr_do", bus.csr_do, 8'h31);
        @(negedge clk);
        check("wr_ack", bus.m1_ack, 1);
        bus.m1_req = 0;
        exp_mem[5'h1a] = 8'h31;
        @(negedge clk);
        check("wr_idle_busy", bus.busy, 0);

        // Both masters request continuously: acks alternate m0,m1,m0,m1 every 4 cycles
        bus.m0_req = 1; bus.m0_a = 5'h1a; bus.m0_we = 0;
        bus.m1_req = 1; bus.m1_a = 5'h07; bus.m1_we = 0;
        for (int off = 1; off <= 17; off++) begin
            @(negedge clk);
            idx = (off - 3) / 4;
            e0 = (off >= 3) && ((off - 3) % 4 == 0) && (idx < 4) && (idx % 2 == 0);
            e1 = (off >= 3) && ((off - 3) % 4 == 0) && (idx < 4) && (idx % 2 == 1);
            check("rr_m0_ack", bus.m0_ack, e0);
            check("rr_m1_ack", bus.m1_ack, e1);
            if (e0) check("rr_m0_rdata", bus.m0_rdata, exp_mem[5'h1a]);
            if (e1) check("rr_m1_rdata", bus.m1_rdata, exp_mem[5'h07]);
            if (off == 15) begin
                bus.m0_req = 0;
                bus.m1_req = 0;
            end
            if (off >= 16) check("rr_drained_busy", bus.busy, 0);
        end

        // Locked read-modify-write by m1 while m0 waits
        bus.m1_req = 1; bus.m1_a = 5'h0a; bus.m1_we = 0; bus.m1_lock = 1;
        @(negedge clk);
        check("lk_first_owner", bus.owner, 1);
        bus.m0_req = 1; bus.m0_a = 5'h0b; bus.m0_we = 0; bus.m0_lock = 0;
        wait_ack(1, "lk_read");
        check("lk_read_rdata", bus.m1_rdata, exp_mem[5'h0a]);
        bus.m1_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lk_m0_held_off", bus.busy, 0);
        end
        bus.m1_req = 1; bus.m1_a = 5'h0c; bus.m1_we = 1; bus.m1_wdata = 8'h77;
        @(negedge clk);
        check("lk_write_busy", bus.busy, 1);
        check("lk_write_owner", bus.owner, 1);
        check("lk_write_csr_we", bus.csr_we, 1);
        check("lk_write_csr_a", bus.csr_a, 5'h0c);
        wait_ack(1, "lk_write");
        bus.m1_req = 0; bus.m1_lock = 0;
        exp_mem[5'h0c] = 8'h77;
        @(negedge clk);
        check("lk_release_idle", bus.busy, 0);
        @(negedge clk);
        check("lk_m0_granted", bus.busy, 1);
        check("lk_m0_owner", bus.owner, 0);
        check("lk_m0_csr_a", bus.csr_a, 5'h0b);
        wait_ack(0, "lk_m0");
        check("lk_m0_rdata", bus.m0_rdata, exp_mem[5'h0b]);
        bus.m0_req = 0;

        // m0 locks then idles: timeout after 4 idle cycles, then m1 is granted
        @(negedge clk);
        bus.m0_req = 1; bus.m0_a = 5'h03; bus.m0_we = 0; bus.m0_lock = 1;
        @(negedge clk);
        check("to_m0_owner", bus.owner, 0);
        bus.m1_req = 1; bus.m1_a = 5'h1a; bus.m1_we = 0; bus.m1_lock = 0;
        wait_ack(0, "to_m0");
        bus.m0_req = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("to_no_pulse_yet", bus.lock_timeout, 0);
            check("to_m1_held_off", bus.busy, 0);
        end
        @(negedge clk);
        check("to_pulse", bus.lock_timeout, 1);
        check("to_pulse_busy", bus.busy, 0);
        @(negedge clk);
        check("to_pulse_one_cycle", bus.lock_timeout, 0);
        check("to_m1_granted", bus.busy, 1);
        check("to_m1_owner", bus.owner, 1);
        check("to_m1_csr_a", bus.csr_a, 5'h1a);
        bus.m0_lock = 0;
        wait_ack(1, "to_m1");
        check("to_m1_rdata", bus.m1_rdata, exp_mem[5'h1a]);
        bus.m1_req = 0;

        // m0 withdraws before being granted: no further bus activity
        @(negedge clk);
        bus.m1_req = 1; bus.m1_a = 5'h07; bus.m1_we = 0;
        @(negedge clk);
        bus.m0_req = 1; bus.m0_a = 5'h09; bus.m0_we = 1; bus.m0_wdata = 8'h99;
        @(negedge clk);
        bus.m0_req = 0;
        wait_ack(1, "wd_m1");
        bus.m1_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wd_no_grant", bus.busy, 0);
            check("wd_no_strobe", bus.csr_we, 0);
        end

        // Reset during WAIT of an m0 write
        bus.m0_req = 1; bus.m0_a = 5'h05; bus.m0_we = 1; bus.m0_wdata = 8'h55;
        @(negedge clk);
        check("mr_addr_csr_we", bus.csr_we, 1);
        @(negedge clk);
        rst = 1'b1;
        bus.m0_req = 0;
        @(negedge clk);
        check("mr_no_ack", bus.m0_ack, 0);
        check("mr_csr_we", bus.csr_we, 0);
        check("mr_csr_a", bus.csr_a, IDLE_A);
        check("mr_busy", bus.busy, 0);
        rst = 1'b0;
        reset_model();
        bus.m1_req = 1; bus.m1_a = 5'h05; bus.m1_we = 0;
        @(negedge clk);
        check("mr_m1_owner", bus.owner, 1);
        wait_ack(1, "mr_m1");
        check("mr_m1_rdata", bus.m1_rdata, exp_mem[5'h05]);
        bus.m1_req = 0;

        // Random traffic; after the last ack (m1) the pointer favours m0
        pref = 0; prev_busy = 0; gcyc = 0; g_owner = 0;
        for (int j = 0; j < 2; j++) begin
            pend[j] = 0; prev_req[j] = 0; age[j] = 0;
            ra[j] = '0; rwe[j] = 0; rwd[j] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            rose = bus.busy && !prev_busy;
            if (rose) begin
                g_owner = int'(bus.owner);
                gcyc    = cyc;
                check("rnd_grant_had_req", prev_req[g_owner], 1);
                if (prev_req[0] && prev_req[1]) check("rnd_rr_winner", g_owner, pref);
                check("rnd_addr", bus.csr_a, ra[g_owner]);
                check("rnd_strobe", bus.csr_we, rwe[g_owner]);
                if (rwe[g_owner]) check("rnd_wdata", bus.csr_do, rwd[g_owner]);
            end else begin
                check("rnd_no_strobe", bus.csr_we, 0);
            end
            ack_v[0] = bus.m0_ack;   ack_v[1] = bus.m1_ack;
            rd_v[0]  = bus.m0_rdata; rd_v[1]  = bus.m1_rdata;
            for (int j = 0; j < 2; j++) begin
                if (ack_v[j]) begin
                    check("rnd_ack_pending", pend[j], 1);
                    check("rnd_ack_owner", j, g_owner);
                    check("rnd_ack_latency", cyc - gcyc, RL + 1);
                    check("rnd_wait_bound", age[j] <= 12, 1);
                    if (rwe[j]) exp_mem[ra[j]] = rwd[j];
                    else        check("rnd_rdata", rd_v[j], exp_mem[ra[j]]);
                    pend[j] = 0;
                    pref    = 1 - j;
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (!pend[j]) begin
                    if (cyc < 1460 && $urandom_range(0, 2) == 0) begin
                        pend[j] = 1;
                        age[j]  = 0;
                        ra[j]   = 5'($urandom_range(0, 30));
                        rwe[j]  = 1'($urandom_range(0, 1));
                        rwd[j]  = 8'($urandom);
                    end
                end else begin
                    age[j]++;
                end
            end
            bus.m0_req = pend[0]; bus.m0_a = ra[0]; bus.m0_we = rwe[0]; bus.m0_wdata = rwd[0];
            bus.m1_req = pend[1]; bus.m1_a = ra[1]; bus.m1_we = rwe[1]; bus.m1_wdata = rwd[1];
            prev_req[0] = pend[0];
            prev_req[1] = pend[1];
            prev_busy   = bus.busy;
        end
        check("rnd_all_served", pend[0] | pend[1], 0);
        check("rnd_final_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_arbiter.md
Name: csr_arbiter

Overview:
- Shares the 5-bit address / 8-bit data CSR register bus between two bus masters.
- Master 0 is the I2C slave bridge. Master 1 is an internal requester, e.g. a boot-time config loader or sequencer.
- Sequences each access as address → write strobe → read-data sample → acknowledge.
- Uses round-robin arbitration with an optional lock for atomic read-modify-write. Sits between the masters and the OR-reduced CSR slave bus.

Parameters:
- READ_LATENCY, 1: cycles from address valid to csr_di sampling; legal 1..3.
- IDLE_ADDR, 5'h1f: address driven on csr_a when the bus is idle; must be an unused address.
- LOCK_TIMEOUT, 8'd255: cycles a locked owner may sit idle before its lock is forcibly released.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 transfer request, level.
- m0_a  in  5  master 0 address.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_wdata  in  8  master 0 write data.
- m0_lock  in  1  master 0 keeps ownership after current transfer.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m0_rdata  out  8  read data, valid while m0_ack=1.
- m1_req, m1_a, m1_we, m1_wdata, m1_lock, m1_ack, m1_rdata: same as m0_*, for master 1.
- csr_a  out  5  CSR bus address.
- csr_do  out  8  CSR bus write data (to slave csr_di).
- csr_we  out  1  CSR bus write strobe.
- csr_di  in  8  OR-reduced slave read data.
- busy  out  1  transfer in progress (any state other than IDLE).
- owner  out  1  master of the current or last transfer.
- lock_timeout  out  1  one-cycle pulse on a forced lock release.

Behaviour:
- Reset values: all outputs registered.
  - csr_a=IDLE_ADDR; csr_do=0; csr_we=0.
  - m0_ack=m1_ack=0; m0_rdata=m1_rdata=0.
  - busy=0; owner=0; lock_timeout=0.
  - Round-robin pointer favours master 0; lock released; timeout counter 0.
- FSM states: IDLE, ADDR, WAIT, ACK.
- IDLE:
  - If unlocked and exactly one req is high, grant it.
  - If both are high, grant the master the pointer favours.
  - If locked, consider only the lock owner's req; the other master waits.
  - On grant: latch a/we/wdata of the winner, set owner, go to ADDR.
- ADDR (1 cycle):
  - csr_a=latched address; csr_do=latched data; csr_we=latched we.
  - csr_we is high for exactly this one cycle; it is never high in any other state.
- WAIT (READ_LATENCY cycles):
  - csr_a/csr_do held, csr_we=0.
  - On the last WAIT cycle, register csr_di into the owner's rdata. Sampled for writes too; harmless.
- ACK (1 cycle):
  - Owner's ack=1, its rdata valid.
  - Pointer moves to the other master.
  - Lock state := owner's lock input sampled this cycle.
  - Next state IDLE. csr_a returns to IDLE_ADDR on entry to IDLE.
- Latency:
  - Request high in IDLE at cycle T gives ADDR at T+1 and ack at T+2+READ_LATENCY (T+3 at default).
  - Minimum repeat period is READ_LATENCY+3 cycles.
- Handshake:
  - A master holds req/a/we/wdata until ack. Inputs are latched at grant; later changes are ignored.
  - A master must drop req (or present its next transfer) by the cycle after ack.
  - Dropping req before grant withdraws the request; no bus activity results.
- Lock:
  - While locked and in IDLE with the owner's req low, an 8-bit counter increments.
  - Reaching LOCK_TIMEOUT clears the lock, pulses lock_timeout, and resets the counter.
  - Lock is also cleared when the owner's lock input is low in IDLE.
  - The counter clears on every grant.
- Simultaneous events:
  - Both req in the same IDLE cycle: the pointer decides.
  - Lock expiry and the other master's req in the same cycle: the lock is released this cycle; the grant is evaluated in the next IDLE cycle.
- Reset mid-transfer: at the next edge return to IDLE with reset values. No ack is issued; csr_we is dropped. The aborted master must re-request.
- Counter widths: the WAIT counter is 2 bits. The timeout compare is ≥ LOCK_TIMEOUT, saturating, with no wrap.

Test Plan:
- m0 read from a=5'h03, slave returns 8'h20 → csr_a=03 at T+1, csr_we=0 throughout, m0_ack at T+3 with m0_rdata=8'h20, csr_a=1f at T+4.
- m1 write a=5'h1a data 8'h31 → csr_we high exactly one cycle (T+1) with csr_a=1a and csr_do=31, m1_ack at T+3.
- m0 and m1 both request continuously for 4 transfers after reset → grants alternate m0, m1, m0, m1; each ack is 4 cycles apart.
- m1 read with m1_lock=1, then m1 write within 10 cycles while m0_req is held high → m1 completes both before m0 is granted; m0 is granted after m1 drops lock.
- m0 locks and idles with LOCK_TIMEOUT=8'd4 and m1_req high → lock_timeout pulses after 4 idle cycles; m1 is granted the following cycle.
- rst asserted in the WAIT state of an m0 write → no m0_ack, csr_we=0, csr_a=1f, busy=0 the next cycle; a new m1 request completes normally afterwards.
